commit_trace_unit: RTL and testbench

- Synthesizable commit/event tracer for the rv32i core. Replaces ad-hoc testbench $fwrite logging with on-chip capture.
- NUM_CH event channels (e.g. regfile write, load, store, jal/jalr/br) are arbitrated round-robin into a DEPTH-entry circular trace FIFO. Each entry carries a cycle timestamp.
- Also tracks the commit order count, self-loop halt detection and a no-commit watchdog. Sits beside the core datapath; its outputs feed a debug port or the bench.

---
 rtl/commit_trace_unit.sv | 189 ++++++++++++++++++
 tb/tb_commit_trace_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_unit.sv
// Commit/event tracer: round-robin capture of NUM_CH event channels into a
// timestamped circular FIFO, plus commit order count, self-loop halt
// detection and a no-commit watchdog.
module commit_trace_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TS_W    = 32,
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    overwrite,
  input  logic [NUM_CH-1:0]       ch_valid,
  output logic [NUM_CH-1:0]       ch_ready,
  input  logic [NUM_CH*WIDTH-1:0] ch_pc,
  input  logic [NUM_CH*WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  input  logic                    commit,
  input  logic [WIDTH-1:0]        pc_rdata,
  input  logic [WIDTH-1:0]        pc_wdata,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [CH_W-1:0]         rd_ch,
  output logic [WIDTH-1:0]        rd_pc,
  output logic [WIDTH-1:0]        rd_addr,
  output logic [WIDTH-1:0]        rd_data,
  output logic [TS_W-1:0]         rd_ts,
  output logic [CW-1:0]           count,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [63:0]             order,
  output logic                    halt,
  output logic                    timeout
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned IW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [IW-1:0] TMO_C   = IW'(TIMEOUT);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] data;
    logic [TS_W-1:0]  ts;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           wr_entry, head_entry;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CH_W-1:0]  rr_q, rr_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [63:0]      order_q, order_d;
  logic             halt_q, halt_d, timeout_q, timeout_d;
  logic [IW-1:0]    idle_q, idle_d;

  logic             grant_found;
  logic [CH_W-1:0]  grant_idx, cand;
  int unsigned      idx;
  logic             empty, full, can_push, push, pop;

  // Round-robin search starting at rr_q; the first requesting channel wins
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CH_W'(idx);
      if (!grant_found && ch_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Handshake, head read-out and next-state for FIFO, arbiter and commit tracking
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == DEPTH_C);
    // ready is based on the registered count, so a same-cycle pop never frees a slot
    can_push = rst & ~clear & (~full | overwrite);
    push     = grant_found & can_push;
    pop      = ~empty & rd_ready & ~clear;
    ch_ready = push ? (NUM_CH'(1) << grant_idx) : '0;

    wr_entry.ch   = grant_idx;
    wr_entry.pc   = ch_pc[32'(grant_idx) * WIDTH +: WIDTH];
    wr_entry.addr = ch_addr[32'(grant_idx) * WIDTH +: WIDTH];
    wr_entry.data = ch_data[32'(grant_idx) * WIDTH +: WIDTH];
    wr_entry.ts   = ts_q;

    head_entry = mem_q[head_q];
    rd_valid   = ~empty;
    rd_ch      = empty ? '0 : head_entry.ch;
    rd_pc      = empty ? '0 : head_entry.pc;
    rd_addr    = empty ? '0 : head_entry.addr;
    rd_data    = empty ? '0 : head_entry.data;
    rd_ts      = empty ? '0 : head_entry.ts;

    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    drop_d    = drop_q;
    rr_d      = rr_q;
    ts_d      = ts_q + 1'b1;
    order_d   = order_q;
    halt_d    = halt_q;
    idle_d    = idle_q;
    timeout_d = timeout_q;

    if (clear) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      drop_d    = '0;
      rr_d      = '0;
      order_d   = '0;
      halt_d    = 1'b0;
      idle_d    = '0;
      timeout_d = 1'b0;
    end else begin
      if (push) begin
        tail_d = tail_q + 1'b1;
        rr_d   = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
      end
      // a pop and an overwrite discard both retire the head slot; only one step is needed
      if (pop || (push && full)) head_d = head_q + 1'b1;
      if (push && full && !pop && (drop_q != '1)) drop_d = drop_q + 1'b1;
      if (push && !pop && !full) count_d = count_q + 1'b1;
      else if (pop && !push)     count_d = count_q - 1'b1;

      order_d = order_q + 64'(commit);
      halt_d  = halt_q | (commit & (pc_rdata == pc_wdata));
      if (commit)              idle_d = '0;
      else if (idle_q != TMO_C) idle_d = idle_q + 1'b1;
      timeout_d = timeout_q | (idle_d == TMO_C);
    end
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      drop_q    <= '0;
      rr_q      <= '0;
      ts_q      <= '0;
      order_q   <= '0;
      halt_q    <= 1'b0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      drop_q    <= drop_d;
      rr_q      <= rr_d;
      ts_q      <= ts_d;
      order_q   <= order_d;
      halt_q    <= halt_d;
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  // Trace storage; unread slots are masked at the output so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= wr_entry;
  end

  assign count    = count_q;
  assign drop_cnt = drop_q;
  assign order    = order_q;
  assign halt     = halt_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_commit_trace_unit.sv
// Directed bench for commit_trace_unit with a queue-based scoreboard.
module tb_commit_trace_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clear = 1'b0;
  logic         overwrite = 1'b0;
  logic [3:0]   ch_valid = '0;
  logic [3:0]   ch_ready;
  logic [127:0] ch_pc = '0, ch_addr = '0, ch_data = '0;
  logic         commit = 1'b0;
  logic [31:0]  pc_rdata = '0, pc_wdata = '0;
  logic         rd_valid;
  logic         rd_ready = 1'b0;
  logic [1:0]   rd_ch;
  logic [31:0]  rd_pc, rd_addr, rd_data, rd_ts;
  logic [4:0]   count;
  logic [15:0]  drop_cnt;
  logic [63:0]  order;
  logic         halt, timeout;

  commit_trace_unit #(
    .WIDTH(32), .NUM_CH(4), .DEPTH(16), .TS_W(32), .TIMEOUT(10), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .overwrite(overwrite),
    .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_pc(ch_pc), .ch_addr(ch_addr), .ch_data(ch_data),
    .commit(commit), .pc_rdata(pc_rdata), .pc_wdata(pc_wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ch(rd_ch),
    .rd_pc(rd_pc), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ts(rd_ts),
    .count(count), .drop_cnt(drop_cnt), .order(order),
    .halt(halt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] ts;
  } exp_t;

  exp_t exp_q[$];
  int   errs = 0;
  int   checks = 0;

  // Reference cycle counter: counts rising edges since reset release
  logic [31:0] tb_ts;
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_ts <= '0;
    else      tb_ts <= tb_ts + 1;
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  // Monitor: every head handshake is compared against the oldest expected entry
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL sb_unexpected: got ch=%0d data=0x%0h, required no entry", rd_ch, rd_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_ch",   64'(rd_ch), 64'(e.ch));
        chk("sb_pc",   64'(rd_pc), 64'(e.pc));
        chk("sb_addr", 64'(rd_addr), 64'(e.addr));
        chk("sb_data", 64'(rd_data), 64'(e.data));
        chk("sb_ts",   64'(rd_ts), 64'(e.ts));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [31:0] pc, input logic [31:0] addr,
                        input logic [31:0] data);
    ch_pc[c*32 +: 32]   = pc;
    ch_addr[c*32 +: 32] = addr;
    ch_data[c*32 +: 32] = data;
  endtask

  // Single-channel request; discard drops the expected head (overwrite without pop)
  task automatic push_one(input int c, input logic [31:0] pc, input logic [31:0] addr,
                          input logic [31:0] data, input bit discard);
    logic [3:0] onehot;
    onehot = 4'b0001 << c;
    set_ch(c, pc, addr, data);
    ch_valid = onehot;
    @(negedge clk);
    chk($sformatf("ready_ch%0d", c), 64'(ch_ready), 64'(onehot));
    if (discard) void'(exp_q.pop_front());
    exp_q.push_back('{ch: c, pc: pc, addr: addr, data: data, ts: tb_ts});
    tick();
    ch_valid = '0;
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int i = 0; i < 40 && rd_valid; i++) tick();
    rd_ready = 1'b0;
    chk("drain_empty", 64'(rd_valid), 64'(0));
    chk("sb_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "bench time limit");
  end

  initial begin : stim
    // Reset state, with requests present
    ch_valid = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",   64'(ch_ready), 64'(0));
    chk("rst_count",   64'(count), 64'(0));
    chk("rst_valid",   64'(rd_valid), 64'(0));
    chk("rst_data",    64'(rd_data), 64'(0));
    chk("rst_drop",    64'(drop_cnt), 64'(0));
    chk("rst_order",   order, 64'(0));
    chk("rst_halt",    64'(halt), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    ch_valid = '0;
    rst = 1'b1;

    // Basic capture from three channels, plus two ordinary commits
    push_one(2, 32'h100, 32'h4, 32'hdead, 1'b0);
    push_one(0, 32'h200, 32'h8, 32'hbeef, 1'b0);
    push_one(3, 32'h300, 32'hc, 32'hcafe, 1'b0);
    chk("basic_count", 64'(count), 64'(3));
    commit = 1'b1; pc_rdata = 32'h10; pc_wdata = 32'h14;
    tick();
    pc_rdata = 32'h14; pc_wdata = 32'h20;
    tick();
    commit = 1'b0;
    chk("basic_order", order, 64'(2));
    chk("basic_halt",  64'(halt), 64'(0));
    drain();
    chk("empty_ts", 64'(rd_ts), 64'(0));

    // Reset in the middle of operation acts without a clock edge
    for (int i = 0; i < 5; i++) push_one(0, 32'h400 + i * 4, i, i, 1'b0);
    chk("mid_count5", 64'(count), 64'(5));
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_count", 64'(count), 64'(0));
    chk("mid_rst_valid", 64'(rd_valid), 64'(0));
    chk("mid_rst_order", order, 64'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_one(1, 32'h500, 32'h1, 32'h55, 1'b0);
    chk("ts_restart", 64'(rd_ts), 64'(0));
    drain();

    // Round robin with all channels requesting, no pops, backpressure mode
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int c = 0; c < 4; c++) set_ch(c, 32'h1000 + c * 4, c, 32'h100 + c);
    ch_valid = 4'hF;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("rr_grant%0d", k), 64'(ch_ready), 64'(4'b0001 << (k % 4)));
      exp_q.push_back('{ch: k % 4, pc: 32'h1000 + (k % 4) * 4, addr: k % 4,
                        data: 32'h100 + (k % 4), ts: tb_ts});
    end
    @(posedge clk);
    #1;
    chk("rr_full_count", 64'(count), 64'(16));
    rd_ready = 1'b1;
    @(negedge clk);
    chk("full_bp_ready", 64'(ch_ready), 64'(0));
    @(posedge clk);
    #1;
    ch_valid = '0;
    drain();

    // Overwrite of the oldest entry when full
    for (int i = 0; i < 16; i++) push_one(0, 32'h2000 + i * 4, 32'h40 + i, i, 1'b0);
    chk("ow_fill_count", 64'(count), 64'(16));
    overwrite = 1'b1;
    push_one(0, 32'h2040, 32'h50, 32'd16, 1'b1);
    chk("ow_count", 64'(count), 64'(16));
    chk("ow_drop",  64'(drop_cnt), 64'(1));
    chk("ow_head",  64'(rd_data), 64'(1));
    rd_ready = 1'b1;
    push_one(0, 32'h2044, 32'h51, 32'd17, 1'b0);
    rd_ready = 1'b0;
    chk("pp_count", 64'(count), 64'(16));
    chk("pp_drop",  64'(drop_cnt), 64'(1));
    chk("pp_head",  64'(rd_data), 64'(2));
    overwrite = 1'b0;
    drain();

    // Self-loop halt detection, then clear of everything
    push_one(1, 32'h3000, 32'h1, 32'h11, 1'b0);
    push_one(2, 32'h3004, 32'h2, 32'h22, 1'b0);
    commit = 1'b1; pc_rdata = 32'h60; pc_wdata = 32'h60;
    tick();
    chk("halt_set",  64'(halt), 64'(1));
    chk("halt_order", order, 64'(1));
    pc_rdata = 32'h64; pc_wdata = 32'h68;
    tick();
    commit = 1'b0;
    chk("halt_sticky", 64'(halt), 64'(1));
    chk("halt_order2", order, 64'(2));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
    chk("clr_count", 64'(count), 64'(0));
    chk("clr_valid", 64'(rd_valid), 64'(0));
    chk("clr_drop",  64'(drop_cnt), 64'(0));
    chk("clr_order", order, 64'(0));
    chk("clr_halt",  64'(halt), 64'(0));

    // Watchdog: fires after exactly TIMEOUT idle cycles, sticky until clear
    commit = 1'b1; pc_rdata = 32'h70; pc_wdata = 32'h74;
    tick();
    commit = 1'b0;
    repeat (9) tick();
    chk("wd_before", 64'(timeout), 64'(0));
    tick();
    chk("wd_fire", 64'(timeout), 64'(1));
    commit = 1'b1; pc_rdata = 32'h80; pc_wdata = 32'h84;
    tick();
    commit = 1'b0;
    chk("wd_sticky", 64'(timeout), 64'(1));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("wd_clear", 64'(timeout), 64'(0));

    chk("sb_final", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
